mem_op_controller: RTL and testbench

Memory-operation sequencer between the microprogrammed control unit and the single-port RAM. It accepts a CPU access request (MOV/RW/size, address and write data from MAR/MDR) and a boot-loader write port, arbitrates between them, and drives the RAM strobes for a fixed number of wait states. It returns MOC to the control unit's condition mux and flags misaligned or reserved-size accesses. It sequences every fetch, load and store the CPU issues.

---
 rtl/mem_op_controller_pkg.sv | 10 +
 rtl/mem_op_controller_if.sv | 29 ++
 rtl/mem_op_controller_align_check.sv | 10 +
 rtl/mem_op_controller.sv | 114 +++++++++++
 tb/tb_mem_op_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_op_controller_pkg.sv
// mem_op_controller_pkg: shared encodings and helpers for the memory-operation sequencer
package mem_op_controller_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  function automatic logic [31:0] zext(input size_e s, input logic [31:0] d);
    return s == SZ_BYTE ? {24'h0, d[7:0]} : s == SZ_HALF ? {16'h0, d[15:0]} : d;
  endfunction
endpackage

// File: rtl/mem_op_controller_if.sv
// mem_op_controller_if: CPU, loader and RAM signals of the memory-operation sequencer
interface mem_op_controller_if #(parameter int ADDR_W = 9);
  logic MOV;
  logic RW;
  logic [1:0] Size;
  logic [ADDR_W-1:0] Addr;
  logic [31:0] WrData;
  logic MOC;
  logic [31:0] RdData;
  logic Err;
  logic Ld_Req;
  logic [ADDR_W-1:0] Ld_Addr;
  logic [31:0] Ld_Data;
  logic Ld_Ack;
  logic Ram_En;
  logic Ram_RW;
  logic [1:0] Ram_Size;
  logic [ADDR_W-1:0] Ram_Addr;
  logic [31:0] Ram_DIn;
  logic [31:0] Ram_DOut;
  modport slave (
    input MOV, RW, Size, Addr, WrData, Ld_Req, Ld_Addr, Ld_Data, Ram_DOut,
    output MOC, RdData, Err, Ld_Ack, Ram_En, Ram_RW, Ram_Size, Ram_Addr, Ram_DIn
  );
  modport master (
    output MOV, RW, Size, Addr, WrData, Ld_Req, Ld_Addr, Ld_Data, Ram_DOut,
    input MOC, RdData, Err, Ld_Ack, Ram_En, Ram_RW, Ram_Size, Ram_Addr, Ram_DIn
  );
endinterface

// File: rtl/mem_op_controller_align_check.sv
// mem_align_check: combinational size/address legality check
module mem_align_check
  import mem_op_controller_pkg::*;
(
  input  size_e      size,
  input  logic [1:0] addr_lo,
  output logic       ok
);
  assign ok = size == SZ_HALF ? !addr_lo[0] : size == SZ_WORD ? addr_lo == 2'b00 : size == SZ_BYTE;
endmodule

// File: rtl/mem_op_controller.sv
// mem_op_controller: arbitrates CPU/loader requests and sequences RAM wait-state cycles
module mem_op_controller
  import mem_op_controller_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic Clk,
  input logic Clr,
  mem_op_controller_if.slave bus
);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
  state_e state_q, state_d;
  size_e size_q, size_d, chk_size;
  logic armed_q, armed_d, own_ld_q, own_ld_d, moc_q, moc_d, err_q, err_d, ack_q, ack_d;
  logic en_q, en_d, rw_q, rw_d, ok;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] din_q, din_d, rd_q, rd_d;
  // The loader always writes whole words, so it shares the word-alignment rule
  assign chk_size = bus.Ld_Req ? SZ_WORD : size_e'(bus.Size);
  mem_align_check u_chk (
    .size(chk_size),
    .addr_lo(bus.Ld_Req ? bus.Ld_Addr[1:0] : bus.Addr[1:0]),
    .ok(ok)
  );
  always_comb begin
    state_d = state_q;
    armed_d = bus.MOV ? armed_q : 1'b1;
    cnt_d = cnt_q;
    own_ld_d = own_ld_q;
    moc_d = 1'b0;
    err_d = 1'b0;
    ack_d = 1'b0;
    rd_d = rd_q;
    en_d = en_q;
    rw_d = rw_q;
    size_d = size_q;
    addr_d = addr_q;
    din_d = din_q;
    if (state_q == IDLE && (bus.Ld_Req || (bus.MOV && armed_q))) begin
      own_ld_d = bus.Ld_Req;
      armed_d = bus.Ld_Req ? armed_d : 1'b0;
      cnt_d = WAIT_L;
      if (ok) begin
        state_d = ACCESS;
        en_d = 1'b1;
        rw_d = bus.Ld_Req ? RW_WRITE : bus.RW;
        size_d = chk_size;
        addr_d = bus.Ld_Req ? bus.Ld_Addr : bus.Addr;
        din_d = bus.Ld_Req ? bus.Ld_Data : bus.WrData;
      end else begin
        state_d = DONE;
        moc_d = !bus.Ld_Req;
        err_d = !bus.Ld_Req;
        ack_d = bus.Ld_Req;
      end
    end else if (state_q == ACCESS && cnt_q == 4'd0) begin
      state_d = DONE;
      moc_d = !own_ld_q;
      ack_d = own_ld_q;
      rd_d = (!own_ld_q && rw_q == RW_READ) ? zext(size_q, bus.Ram_DOut) : rd_q;
      en_d = 1'b0;
      rw_d = RW_WRITE;
      size_d = SZ_BYTE;
      addr_d = '0;
      din_d = '0;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      cnt_q <= '0;
      own_ld_q <= 1'b0;
      moc_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
      rd_q <= '0;
      en_q <= 1'b0;
      rw_q <= RW_WRITE;
      size_q <= SZ_BYTE;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
      own_ld_q <= own_ld_d;
      moc_q <= moc_d;
      err_q <= err_d;
      ack_q <= ack_d;
      rd_q <= rd_d;
      en_q <= en_d;
      rw_q <= rw_d;
      size_q <= size_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  end
  assign bus.MOC = moc_q;
  assign bus.Err = err_q;
  assign bus.Ld_Ack = ack_q;
  assign bus.RdData = rd_q;
  assign bus.Ram_En = en_q;
  assign bus.Ram_RW = rw_q;
  assign bus.Ram_Size = size_q;
  assign bus.Ram_Addr = addr_q;
  assign bus.Ram_DIn = din_q;
endmodule

// File: tb/tb_mem_op_controller.sv
// tb_mem_op_controller: directed scoreboard bench for the memory-operation sequencer
module tb_mem_op_controller;
  localparam int AW = 9;
  localparam int WC = 2;
  typedef struct {
    logic ld;
    logic err;
    logic [31:0] rd;
  } exp_t;
  logic Clk = 1'b0;
  logic Clr = 1'b1;
  exp_t sb[$];
  exp_t cur;
  int total = 0;
  int bad = 0;
  logic [31:0] rd_model = '0;
  always #5 Clk = ~Clk;
  mem_op_controller_if #(.ADDR_W(AW)) bus ();
  mem_op_controller #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  always @(negedge Clk) begin
    if (bus.MOC === 1'b1 || bus.Ld_Ack === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected observed=moc%0b/ack%0b expected=none", bus.MOC, bus.Ld_Ack);
      end else begin
        cur = sb.pop_front();
        chk("sb_moc", 32'(bus.MOC), 32'(!cur.ld));
        chk("sb_ack", 32'(bus.Ld_Ack), 32'(cur.ld));
        chk("sb_err", 32'(bus.Err), 32'(cur.err));
        chk("sb_rd", bus.RdData, cur.rd);
      end
    end
    if (Clr) chk("err_qual", 32'(bus.Err & ~bus.MOC), 32'd0);
  end
  task automatic run_cpu(input string tag, input logic rw, input logic [1:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] dout, input bit rej);
    int en_n = 0;
    int lat = 0;
    logic s_rw = 1'b0;
    logic [1:0] s_sz = '0;
    logic [AW-1:0] s_a = '0;
    logic [31:0] s_d = '0;
    if (!rej && rw) rd_model = sz == 2'b00 ? {24'h0, dout[7:0]} : sz == 2'b01 ? {16'h0, dout[15:0]} : dout;
    sb.push_back('{1'b0, rej, rd_model});
    bus.Ram_DOut = dout;
    bus.RW = rw;
    bus.Size = sz;
    bus.Addr = a;
    bus.WrData = wd;
    bus.MOV = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (i == 1) begin
        bus.Addr = ~a;
        bus.WrData = ~wd;
        bus.RW = ~rw;
      end
      if (bus.Ram_En && en_n == 0) begin
        s_rw = bus.Ram_RW;
        s_sz = bus.Ram_Size;
        s_a = bus.Ram_Addr;
        s_d = bus.Ram_DIn;
      end
      if (bus.Ram_En) en_n++;
      if (bus.MOC) lat = i;
    end
    bus.MOV = 1'b0;
    chk({tag, "_en_cycles"}, 32'(en_n), rej ? 32'd0 : 32'(WC + 1));
    chk({tag, "_moc_cycle"}, 32'(lat), rej ? 32'd1 : 32'(WC + 2));
    if (!rej) begin
      chk({tag, "_ram_rw"}, 32'(s_rw), 32'(rw));
      chk({tag, "_ram_size"}, 32'(s_sz), 32'(sz));
      chk({tag, "_ram_addr"}, 32'(s_a), 32'(a));
      if (!rw) chk({tag, "_ram_din"}, s_d, wd);
    end
  endtask
  initial begin
    int en_n, moc_n, ack_c, moc_c;
    logic [AW-1:0] ld_a;
    logic [31:0] ld_d;
    logic ld_rw;
    bus.MOV = 0; bus.RW = 0; bus.Size = 0; bus.Addr = '0; bus.WrData = '0;
    bus.Ld_Req = 0; bus.Ld_Addr = '0; bus.Ld_Data = '0; bus.Ram_DOut = '0;
    #2 Clr = 1'b0;
    tick();
    tick();
    chk("rst_moc", 32'(bus.MOC), 32'd0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    chk("rst_ack", 32'(bus.Ld_Ack), 32'd0);
    chk("rst_rd", bus.RdData, 32'd0);
    chk("rst_en", 32'(bus.Ram_En), 32'd0);
    chk("rst_addr", 32'(bus.Ram_Addr), 32'd0);
    Clr = 1'b1;
    tick();
    run_cpu("wrd_rd", 1'b1, 2'b10, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    tick();
    run_cpu("byte_rd", 1'b1, 2'b00, 9'h013, 32'h0, 32'h123456A5, 1'b0);
    tick();
    run_cpu("half_rd", 1'b1, 2'b01, 9'h012, 32'h0, 32'h9876C3D4, 1'b0);
    tick();
    run_cpu("half_wr", 1'b0, 2'b01, 9'h012, 32'h00001234, 32'hFFFFFFFF, 1'b0);
    chk("half_wr_keeps_rd", bus.RdData, 32'h0000C3D4);
    tick();
    run_cpu("mis_wrd", 1'b1, 2'b10, 9'h011, 32'h0, 32'h55555555, 1'b1);
    tick();
    run_cpu("mis_half", 1'b0, 2'b01, 9'h015, 32'h77, 32'h0, 1'b1);
    tick();
    run_cpu("rsvd", 1'b1, 2'b11, 9'h000, 32'h0, 32'h0, 1'b1);
    tick();
    sb.push_back('{1'b1, 1'b0, rd_model});
    rd_model = 32'hCAFEF00D;
    sb.push_back('{1'b0, 1'b0, rd_model});
    bus.Ram_DOut = 32'hCAFEF00D;
    bus.Ld_Addr = 9'h020; bus.Ld_Data = 32'hA5A50001; bus.Ld_Req = 1'b1;
    bus.RW = 1'b1; bus.Size = 2'b10; bus.Addr = 9'h010; bus.MOV = 1'b1;
    ack_c = 0; moc_c = 0; ld_a = '0; ld_d = '0; ld_rw = 1'b1;
    for (int i = 1; i <= 30 && moc_c == 0; i++) begin
      tick();
      if (bus.Ram_En && ack_c == 0 && i == 1) begin
        ld_a = bus.Ram_Addr;
        ld_d = bus.Ram_DIn;
        ld_rw = bus.Ram_RW;
      end
      if (bus.Ld_Ack) begin
        ack_c = i;
        bus.Ld_Req = 1'b0;
      end
      if (bus.MOC) moc_c = i;
    end
    bus.MOV = 1'b0;
    chk("tie_ack_cycle", 32'(ack_c), 32'(WC + 2));
    chk("tie_moc_after_ack", 32'(moc_c - ack_c), 32'(WC + 3));
    chk("tie_ld_addr", 32'(ld_a), 32'h020);
    chk("tie_ld_din", ld_d, 32'hA5A50001);
    chk("tie_ld_rw", 32'(ld_rw), 32'd0);
    tick();
    sb.push_back('{1'b1, 1'b0, rd_model});
    bus.Ld_Addr = 9'h021; bus.Ld_Req = 1'b1;
    ack_c = 0; en_n = 0;
    for (int i = 1; i <= 20 && ack_c == 0; i++) begin
      tick();
      if (bus.Ram_En) en_n++;
      if (bus.Ld_Ack) ack_c = i;
    end
    bus.Ld_Req = 1'b0;
    chk("ld_mis_ack_cycle", 32'(ack_c), 32'd1);
    chk("ld_mis_en", 32'(en_n), 32'd0);
    tick();
    rd_model = 32'h11112222;
    sb.push_back('{1'b0, 1'b0, rd_model});
    bus.Ram_DOut = 32'h11112222; bus.RW = 1'b1; bus.Size = 2'b10; bus.Addr = 9'h014; bus.MOV = 1'b1;
    en_n = 0; moc_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Ram_En) en_n++;
      if (bus.MOC) moc_n++;
    end
    bus.MOV = 1'b0;
    chk("held_en_cycles", 32'(en_n), 32'(WC + 1));
    chk("held_moc_count", 32'(moc_n), 32'd1);
    tick();
    run_cpu("rearm", 1'b1, 2'b10, 9'h01C, 32'h0, 32'h33334444, 1'b0);
    tick();
    bus.Ram_DOut = 32'h99999999; bus.RW = 1'b1; bus.Size = 2'b10; bus.Addr = 9'h018; bus.MOV = 1'b1;
    tick();
    tick();
    chk("abort_en_before", 32'(bus.Ram_En), 32'd1);
    Clr = 1'b0;
    #1;
    chk("abort_en_after", 32'(bus.Ram_En), 32'd0);
    chk("abort_rd", bus.RdData, 32'd0);
    bus.MOV = 1'b0;
    rd_model = '0;
    moc_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.MOC) moc_n++;
    end
    Clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.MOC) moc_n++;
    end
    chk("abort_no_moc", 32'(moc_n), 32'd0);
    chk("post_rst_rd", bus.RdData, 32'd0);
    run_cpu("post_rst", 1'b1, 2'b01, 9'h016, 32'h0, 32'h0BADCAFE, 1'b0);
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
